// File: rtl/mult32_seq.sv
// Sequential 32x32 shift-and-add multiplier for mult/multu.
// One partial product per clock; the result lands in the registered HI/LO pair.
module mult32_seq (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        is_signed,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        busy,
   output logic        done,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   logic [1:0]  state;
   logic        sign;
   logic [31:0] m;
   logic [64:0] p;
   logic [4:0]  cnt;

   logic [31:0] mag_a;
   logic [31:0] mag_b;
   logic [32:0] sum;
   logic [63:0] result;

   // 0x80000000 negates to itself, which is exactly 2^31 read as unsigned.
   always_comb begin
      mag_a  = (is_signed & a[31]) ? -a : a;
      mag_b  = (is_signed & b[31]) ? -b : b;
      sum    = p[64:32] + (p[0] ? {1'b0, m} : 33'd0);
      result = sign ? -p[63:0] : p[63:0];
   end

   assign busy = (state == ST_RUN) || (state == ST_DONE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         sign  <= 1'b0;
         m     <= '0;
         p     <= '0;
         cnt   <= '0;
         done  <= 1'b0;
         hi    <= '0;
         lo    <= '0;
      end else begin
         // NOTE: non-blocking everywhere here, so every branch reads pre-edge
         // state; the default below makes done a single-cycle pulse.
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  sign  <= is_signed & (a[31] ^ b[31]);
                  m     <= mag_a;
                  p     <= {33'b0, mag_b};
                  cnt   <= '0;
                  state <= ST_RUN;
               end
            end
            ST_RUN: begin
               p   <= {1'b0, sum, p[31:1]};
               cnt <= cnt + 5'd1;
               if (cnt == 5'd31) state <= ST_DONE;
            end
            ST_DONE: begin
               {hi, lo} <= result;
               done     <= 1'b1;
               state    <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
